// File: rtl/fco_bitslip_align.sv
// Frame-clock word aligner: slips the FCO ISERDES until the deserialised word
// equals PATTERN for LOCK_CHECKS cycles, then watches for sustained loss.
module fco_bitslip_align #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  PATTERN     = 8'hF0,
  parameter int                SETTLE      = 8,
  parameter int                LOCK_CHECKS = 4,
  parameter int                MAX_SLIPS   = 8,
  parameter int                LOSS_THRESH = 2
) (
  input  logic                             CLKDIV,
  input  logic                             rst,
  input  logic                             restart,
  input  logic [WIDTH-1:0]                 fco_data,
  output logic                             bslip,
  output logic                             aligned,
  output logic                             align_err,
  output logic                             lock_lost,
  output logic [$clog2(MAX_SLIPS+1)-1:0]   slip_count
);

  localparam int WW = $clog2(SETTLE);
  localparam int MW = $clog2(LOCK_CHECKS + 1);
  localparam int LW = $clog2(LOSS_THRESH + 1);
  localparam int SW = $clog2(MAX_SLIPS + 1);

  localparam logic [WW-1:0] WAIT_LAST  = WW'(SETTLE - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CHECKS - 1);
  localparam logic [MW-1:0] MATCH_FULL = MW'(LOCK_CHECKS);
  localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_THRESH - 1);
  localparam logic [SW-1:0] SLIP_MAX   = SW'(MAX_SLIPS);

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_POLL    = 3'd1,
    ST_SLIP    = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAIL    = 3'd4
  } state_t;

  state_t        state_q;
  logic [WW-1:0] wait_cnt_q;
  logic [MW-1:0] match_cnt_q;
  logic [LW-1:0] miss_cnt_q;
  logic [SW-1:0] slip_cnt_q;
  logic          bslip_q, aligned_q, align_err_q, lock_lost_q;
  logic          hit;

  assign hit = (fco_data == PATTERN);

  // Outputs are all registered; fco_data only ever reaches flops.
  always_ff @(posedge CLKDIV) begin
    if (rst || restart) begin
      state_q     <= ST_STARTUP;
      wait_cnt_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      slip_cnt_q  <= '0;
      bslip_q     <= 1'b0;
      aligned_q   <= 1'b0;
      align_err_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      bslip_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      case (state_q)
        ST_STARTUP: begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_q     <= ST_POLL;
            wait_cnt_q  <= '0;
            match_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_POLL: begin
          if (hit) begin
            if (match_cnt_q == MATCH_LAST) begin
              state_q     <= ST_LOCKED;
              match_cnt_q <= MATCH_FULL;
              miss_cnt_q  <= '0;
              aligned_q   <= 1'b1;
            end else begin
              match_cnt_q <= match_cnt_q + 1'b1;
            end
          end else if (slip_cnt_q != SLIP_MAX) begin
            state_q     <= ST_SLIP;
            slip_cnt_q  <= slip_cnt_q + 1'b1;
            match_cnt_q <= '0;
            wait_cnt_q  <= '0;
            bslip_q     <= 1'b1;
          end else begin
            state_q     <= ST_FAIL;
            align_err_q <= 1'b1;
          end
        end
        // Hold off sampling while the ISERDES output settles after a slip.
        ST_SLIP: begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_q     <= ST_POLL;
            wait_cnt_q  <= '0;
            match_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (hit) begin
            miss_cnt_q <= '0;
          end else if (miss_cnt_q == MISS_LAST) begin
            state_q     <= ST_POLL;
            miss_cnt_q  <= '0;
            match_cnt_q <= '0;
            slip_cnt_q  <= '0;
            aligned_q   <= 1'b0;
            lock_lost_q <= 1'b1;
          end else begin
            miss_cnt_q <= miss_cnt_q + 1'b1;
          end
        end
        ST_FAIL: begin
          align_err_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_STARTUP;
          wait_cnt_q  <= '0;
          match_cnt_q <= '0;
          miss_cnt_q  <= '0;
          slip_cnt_q  <= '0;
          aligned_q   <= 1'b0;
          align_err_q <= 1'b0;
        end
      endcase
    end
  end

  assign bslip      = bslip_q;
  assign aligned    = aligned_q;
  assign align_err  = align_err_q;
  assign lock_lost  = lock_lost_q;
  assign slip_count = slip_cnt_q;

endmodule
